// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, FSM state type and datapath helper functions.
package rv32i_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011
   } opcode_t;

   // branch funct3
   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   // load/store funct3
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_EXEC, ST_MEM_RD, ST_MEM_WR
   } state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

   // alt selects SUB for ADD and arithmetic shift for SR
   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (f3)
         F3_ADD:  r = alt ? (a - b) : (a + b);
         F3_SLL:  r = a << b[4:0];
         F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         F3_SLTU: r = {31'b0, a < b};
         F3_XOR:  r = a ^ b;
         F3_SR:   r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         F3_OR:   r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
      logic t;
      case (f3)
         F3_BEQ:  t = (a == b);
         F3_BNE:  t = (a != b);
         F3_BLT:  t = ($signed(a) < $signed(b));
         F3_BGE:  t = ($signed(a) >= $signed(b));
         F3_BLTU: t = (a < b);
         F3_BGEU: t = (a >= b);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mp3_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port, x0 reads as zero.
module mp3_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b
);

   logic [31:0] regs [32];

   // Register array; writes to x0 are dropped so the entry stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mp3_core.sv
// Multicycle RV32I core talking directly to a 256-bit line memory; stores are read-modify-write.
module mp3_core
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pmem_resp,
   input  logic [255:0] pmem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata
);

   state_t        state_reg, state_next;
   logic [31:0]   pc_reg, ir_reg, ea_reg;
   logic [255:0]  line_reg;

   opcode_t       opcode;
   logic [2:0]    f3;
   logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0]   rs1_val, rs2_val, alu_b, alu_res, pc_exec, ea_exec;
   logic          alu_alt;
   logic [31:0]   load_val;
   logic [255:0]  store_line;
   logic          rf_we;
   logic [31:0]   rf_wdata;

   assign opcode = opcode_t'(ir_reg[6:0]);
   assign f3     = ir_reg[14:12];
   assign imm_i  = {{20{ir_reg[31]}}, ir_reg[31:20]};
   assign imm_s  = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
   assign imm_b  = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
   assign imm_u  = {ir_reg[31:12], 12'b0};
   assign imm_j  = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};

   mp3_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (ir_reg[11:7]),
      .wdata   (rf_wdata),
      .raddr_a (ir_reg[19:15]),
      .raddr_b (ir_reg[24:20]),
      .rdata_a (rs1_val),
      .rdata_b (rs2_val)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // FSM next-state: memory states hold until pmem_resp.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   state_next = ST_FETCH;
         ST_FETCH:  if (pmem_resp) state_next = ST_EXEC;
         ST_EXEC:   state_next = (opcode == OPC_LOAD || opcode == OPC_STORE) ? ST_MEM_RD : ST_FETCH;
         ST_MEM_RD: if (pmem_resp) state_next = (opcode == OPC_STORE) ? ST_MEM_WR : ST_FETCH;
         ST_MEM_WR: if (pmem_resp) state_next = ST_FETCH;
         default:   state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: memory request lines decoded purely from state.
   always_comb begin
      pmem_read    = (state_reg == ST_FETCH) || (state_reg == ST_MEM_RD);
      pmem_write   = (state_reg == ST_MEM_WR);
      pmem_address = (state_reg == ST_MEM_RD || state_reg == ST_MEM_WR) ?
                     {ea_reg[31:5], 5'b0} : {pc_reg[31:5], 5'b0};
      pmem_wdata   = line_reg;
   end

   // Execute-stage arithmetic: ALU, next pc and effective address.
   always_comb begin
      alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
      alu_alt = (opcode == OPC_OP) ? ir_reg[30] : ((f3 == F3_SR) && ir_reg[30]);
      alu_res = alu(f3, alu_alt, rs1_val, alu_b);
      ea_exec = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
      case (opcode)
         OPC_JAL:    pc_exec = pc_reg + imm_j;
         OPC_JALR:   pc_exec = (rs1_val + imm_i) & ~32'd1;
         OPC_BRANCH: pc_exec = br_taken(f3, rs1_val, rs2_val) ? (pc_reg + imm_b) : (pc_reg + 32'd4);
         OPC_LOAD,
         OPC_STORE:  pc_exec = pc_reg;
         default:    pc_exec = pc_reg + 32'd4;
      endcase
   end

   // Lane selection within the returned line for loads and store merging.
   always_comb begin
      case (f3)
         F3_LB:   load_val = {{24{pmem_rdata[{ea_reg[4:0], 3'b000} + 7]}}, pmem_rdata[{ea_reg[4:0], 3'b000} +: 8]};
         F3_LH:   load_val = {{16{pmem_rdata[{ea_reg[4:1], 4'b0000} + 15]}}, pmem_rdata[{ea_reg[4:1], 4'b0000} +: 16]};
         F3_LBU:  load_val = {24'b0, pmem_rdata[{ea_reg[4:0], 3'b000} +: 8]};
         F3_LHU:  load_val = {16'b0, pmem_rdata[{ea_reg[4:1], 4'b0000} +: 16]};
         default: load_val = pmem_rdata[{ea_reg[4:2], 5'b00000} +: 32];
      endcase
      store_line = pmem_rdata;
      case (f3)
         F3_SB:   store_line[{ea_reg[4:0], 3'b000} +: 8]    = rs2_val[7:0];
         F3_SH:   store_line[{ea_reg[4:1], 4'b0000} +: 16]  = rs2_val[15:0];
         default: store_line[{ea_reg[4:2], 5'b00000} +: 32] = rs2_val;
      endcase
   end

   // Register writeback: ALU/jump results in EXEC, load data when the line arrives.
   always_comb begin
      rf_we    = 1'b0;
      rf_wdata = '0;
      if (state_reg == ST_EXEC) begin
         case (opcode)
            OPC_LUI:    begin rf_we = 1'b1; rf_wdata = imm_u;             end
            OPC_AUIPC:  begin rf_we = 1'b1; rf_wdata = pc_reg + imm_u;    end
            OPC_JAL,
            OPC_JALR:   begin rf_we = 1'b1; rf_wdata = pc_reg + 32'd4;    end
            OPC_OP_IMM,
            OPC_OP:     begin rf_we = 1'b1; rf_wdata = alu_res;           end
            default:    begin rf_we = 1'b0; rf_wdata = '0;                end
         endcase
      end else if (state_reg == ST_MEM_RD && pmem_resp && opcode == OPC_LOAD) begin
         rf_we    = 1'b1;
         rf_wdata = load_val;
      end
   end

   // Architectural state: pc, instruction, effective address and line buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg   <= RESET_PC;
         ir_reg   <= '0;
         ea_reg   <= '0;
         line_reg <= '0;
      end else begin
         case (state_reg)
            ST_FETCH:  if (pmem_resp) ir_reg <= pmem_rdata[{pc_reg[4:2], 5'b00000} +: 32];
            ST_EXEC:   begin
               pc_reg <= pc_exec;
               ea_reg <= ea_exec;
            end
            ST_MEM_RD: if (pmem_resp) begin
               line_reg <= (opcode == OPC_STORE) ? store_line : pmem_rdata;
               if (opcode == OPC_LOAD) pc_reg <= pc_reg + 32'd4;
            end
            ST_MEM_WR: if (pmem_resp) pc_reg <= pc_reg + 32'd4;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_mp3_core.sv
// Directed program bench: expected bus transactions are queued up front, a monitor checks each request.
module tb_mp3_core;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         pmem_resp = 1'b0;
   logic [255:0] pmem_rdata = '0;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;

   mp3_core dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } txn_t;

   logic [255:0] mem [64];
   txn_t         exp_q [$];
   int           n_vec = 0;
   int           n_miss = 0;
   int           n_txn = 0;
   bit           checking = 1'b1;
   int           wait_cnt = 0;
   logic         prev_act = 1'b0;
   logic         prev_resp = 1'b0;

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] i_type(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] s_type(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] b_type(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] j_type(logic [31:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] u_type(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [255:0] line_of(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                                            logic [31:0] w3, logic [31:0] w4, logic [31:0] w5);
      return {64'b0, w5, w4, w3, w2, w1, w0};
   endfunction

   task automatic put(logic [31:0] addr, logic [31:0] instr);
      mem[addr[10:5]][{addr[4:2], 5'b00000} +: 32] = instr;
   endtask
   task automatic exp_r(logic [31:0] addr);
      exp_q.push_back('{wr: 1'b0, addr: addr, data: '0});
   endtask
   task automatic exp_w(logic [31:0] addr, logic [255:0] data);
      exp_q.push_back('{wr: 1'b1, addr: addr, data: data});
   endtask
   task automatic check(string name, logic [255:0] got, logic [255:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Memory model: answers any request after three cycles, one line per transaction.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (pmem_resp) begin
            pmem_resp = 1'b0;
            wait_cnt  = 0;
         end else if (rst_n && (pmem_read || pmem_write)) begin
            wait_cnt++;
            if (wait_cnt >= 3) begin
               if (pmem_write) mem[pmem_address[10:5]] = pmem_wdata;
               else            pmem_rdata = mem[pmem_address[10:5]];
               pmem_resp = 1'b1;
               wait_cnt  = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Monitor: on the first cycle of every request, pop the next expected transaction and compare.
   initial begin
      txn_t e;
      forever begin
         @(negedge clk);
         if (pmem_read && pmem_write) begin
            n_miss++;
            $display("FAIL rw_both: read and write asserted together at addr %h", pmem_address);
         end
         if (rst_n && checking && (pmem_read || pmem_write) && (!prev_act || prev_resp)) begin
            n_txn++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++;
               $display("FAIL txn%0d unexpected: got wr=%0b addr=%h, expected none",
                        n_txn, pmem_write, pmem_address);
            end else begin
               e = exp_q.pop_front();
               if (pmem_write !== e.wr || pmem_address !== e.addr ||
                   (e.wr && pmem_wdata !== e.data)) begin
                  n_miss++;
                  $display("FAIL txn%0d: got wr=%0b addr=%h wdata=%h, expected wr=%0b addr=%h wdata=%h",
                           n_txn, pmem_write, pmem_address, pmem_wdata, e.wr, e.addr, e.data);
               end else begin
                  $display("txn %0d %s addr=%h ok", n_txn, e.wr ? "write" : "read ", e.addr);
               end
            end
         end
         prev_act  = pmem_read || pmem_write;
         prev_resp = pmem_resp;
      end
   end

   task automatic finish_bench();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   endtask

   // Bounded wait, polled just after the active edge.
   task automatic wait_for(string name, int budget, bit use_txn, int target);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (use_txn && n_txn >= target) break;
         if (!use_txn && exp_q.size() == 0) break;
      end
      if (i == budget) begin
         n_vec++;
         n_miss++;
         $display("FAIL timeout %s: txn count %0d, %0d expected transactions left", name, n_txn, exp_q.size());
         finish_bench();
      end
   endtask

   initial begin
      logic [31:0]  a, base, wa;
      logic [255:0] l;
      int           idx;

      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0][63:32]   = 32'hDEADBEEF;              // word at 0x04
      mem[2][159:128] = 32'hFFFFFFFF;              // word at 0x50, overwritten by x0 store
      for (int i = 8; i < 12; i++) mem[i] = '1;    // dump area for the second program

      // ---- program 1 ----
      put(32'h60, i_type(32'd5, 5'd0, 3'd0, 5'd1, 7'h13));      // addi x1,x0,5
      put(32'h64, b_type(32'd16, 5'd0, 5'd0, 3'd0));            // beq x0,x0,+16 -> 0x74
      put(32'h68, i_type(32'd4, 5'd0, 3'd2, 5'd2, 7'h03));      // lw x2,4(x0)
      put(32'h6c, j_type(32'd20, 5'd0));                        // jal x0,+20 -> 0x80
      put(32'h74, b_type(32'd16, 5'd0, 5'd0, 3'd1));            // bne x0,x0,+16 -> 0x78
      put(32'h78, j_type(-32'sd16, 5'd5));                      // jal x5,-16 -> 0x68, x5=0x7c
      put(32'h80, u_type(20'h12345, 5'd3, 7'h37));              // lui x3,0x12345
      put(32'h84, i_type(32'h678, 5'd3, 3'd0, 5'd3, 7'h13));    // addi x3,x3,0x678
      put(32'h88, s_type(32'd33, 5'd3, 5'd0, 3'd0));            // sb x3,33(x0)
      put(32'h8c, i_type(32'd33, 5'd0, 3'd0, 5'd4, 7'h03));     // lb x4,33(x0)
      put(32'h90, i_type(32'd7, 5'd0, 3'd0, 5'd0, 7'h13));      // addi x0,x0,7
      put(32'h94, s_type(32'd64, 5'd1, 5'd0, 3'd2));            // sw x1,64(x0)
      put(32'h98, s_type(32'd68, 5'd2, 5'd0, 3'd2));            // sw x2,68(x0)
      put(32'h9c, s_type(32'd72, 5'd4, 5'd0, 3'd2));            // sw x4,72(x0)
      put(32'ha0, s_type(32'd76, 5'd5, 5'd0, 3'd2));            // sw x5,76(x0)
      put(32'ha4, s_type(32'd80, 5'd0, 5'd0, 3'd2));            // sw x0,80(x0)
      put(32'ha8, i_type(-32'sd16, 5'd0, 3'd0, 5'd7, 7'h13));   // addi x7,x0,-16
      put(32'hac, i_type(32'h402, 5'd7, 3'd5, 5'd8, 7'h13));    // srai x8,x7,2
      put(32'hb0, s_type(32'd84, 5'd8, 5'd0, 3'd2));            // sw x8,84(x0)
      put(32'hb4, i_type(32'd0, 5'd0, 3'd2, 5'd6, 7'h03));      // lw x6,0(x0) (reset lands here)

      // ---- expected bus transactions for program 1 ----
      for (int i = 0; i < 5; i++) exp_r(32'h60);                 // 0x60,0x64,0x74,0x78,0x68
      exp_r(32'h00);                                             // lw data
      exp_r(32'h60);                                             // 0x6c
      for (int i = 0; i < 3; i++) exp_r(32'h80);                 // 0x80,0x84,0x88
      exp_r(32'h20);
      exp_w(32'h20, line_of(32'h00007800, 0, 0, 0, 0, 0));
      exp_r(32'h80); exp_r(32'h20);                              // lb
      exp_r(32'h80);                                             // addi x0
      exp_r(32'h80); exp_r(32'h40);
      exp_w(32'h40, line_of(32'd5, 0, 0, 0, 32'hFFFFFFFF, 0));
      exp_r(32'h80); exp_r(32'h40);
      exp_w(32'h40, line_of(32'd5, 32'hDEADBEEF, 0, 0, 32'hFFFFFFFF, 0));
      exp_r(32'h80); exp_r(32'h40);
      exp_w(32'h40, line_of(32'd5, 32'hDEADBEEF, 32'h78, 0, 32'hFFFFFFFF, 0));
      exp_r(32'ha0); exp_r(32'h40);
      exp_w(32'h40, line_of(32'd5, 32'hDEADBEEF, 32'h78, 32'h7c, 32'hFFFFFFFF, 0));
      exp_r(32'ha0); exp_r(32'h40);
      exp_w(32'h40, line_of(32'd5, 32'hDEADBEEF, 32'h78, 32'h7c, 0, 0));
      exp_r(32'ha0); exp_r(32'ha0);                              // addi x7, srai
      exp_r(32'ha0); exp_r(32'h40);
      exp_w(32'h40, line_of(32'd5, 32'hDEADBEEF, 32'h78, 32'h7c, 0, 32'hFFFFFFFC));
      exp_r(32'ha0);                                             // lw fetch
      exp_r(32'h00);                                             // lw data, interrupted by reset

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("reset_read",  {255'b0, pmem_read},  256'd0);
      check("reset_write", {255'b0, pmem_write}, 256'd0);
      check("reset_addr",  {224'b0, pmem_address}, 256'h60);
      check("reset_wdata", pmem_wdata, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- run program 1 up to the final load's data read, then reset mid-transaction ----
      wait_for("program1", 5000, 1'b1, 37);
      #2;
      check("midrd_read_before", {255'b0, pmem_read}, 256'd1);
      rst_n = 1'b0;
      #1;
      check("midrd_read_drop",  {255'b0, pmem_read},  256'd0);
      check("midrd_write",      {255'b0, pmem_write}, 256'd0);
      check("midrd_addr",       {224'b0, pmem_address}, 256'h60);
      check("prog1_queue_empty", 256'(exp_q.size()), 256'd0);

      // ---- program 2: dump x1..x31 to 0x100.. to prove the register file cleared ----
      for (int i = 1; i <= 31; i++)
         put(32'h60 + 32'(4 * (i - 1)), s_type(32'h100 + 32'(4 * (i - 1)), 5'(i), 5'd0, 3'd2));
      put(32'hdc, j_type(32'd0, 5'd0));                          // park
      for (int i = 1; i <= 31; i++) begin
         a    = 32'h60 + 32'(4 * (i - 1));
         exp_r({a[31:5], 5'b0});
         a    = 32'h100 + 32'(4 * (i - 1));
         base = {a[31:5], 5'b0};
         exp_r(base);
         for (int k = 0; k < 8; k++) begin
            wa  = base + 32'(4 * k);
            idx = int'((wa - 32'h100) >> 2) + 1;
            l[32 * k +: 32] = (idx <= i) ? 32'h0 : 32'hFFFFFFFF;
         end
         exp_w(base, l);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      wait_for("program2", 5000, 1'b0, 0);
      checking = 1'b0;
      repeat (5) @(negedge clk);
      finish_bench();
   end

endmodule
